gcm_frame_feeder: RTL and testbench

//  Transmit side of the stage-1 block interface: turns a frame header plus a block stream into the per-cycle
//  o_aad/o_plain_text/o_new_instance/o_instance_size sequence that the GCM pipeline entry counts. Buffers a

---
 rtl/gcm_frame_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_gcm_frame_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_frame_feeder.sv
// gcm_frame_feeder: buffers one GCM frame (header + block stream) and replays it
// gap-free onto the stage-1 per-cycle block interface of the GCM pipeline.
module gcm_frame_feeder #(
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_hdr_valid,
    output logic         s_hdr_ready,
    input  logic [127:0] s_hdr_key,
    input  logic [95:0]  s_hdr_iv,
    input  logic [63:0]  s_hdr_aad_bits,
    input  logic [63:0]  s_hdr_pt_bits,
    input  logic         s_blk_valid,
    output logic         s_blk_ready,
    input  logic [127:0] s_blk_data,
    input  logic         s_blk_last,
    output logic [127:0] o_cipher_key,
    output logic [127:0] o_aad,
    output logic [127:0] o_plain_text,
    output logic [95:0]  o_iv,
    output logic [127:0] o_instance_size,
    output logic         o_new_instance,
    output logic         o_pt_instance,
    output logic         o_busy,
    output logic         o_err,
    output logic [1:0]   o_err_code
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, CHECK, FILL, SEND, DRAIN} state_t;
    state_t state_q, state_d;

    // Block FIFO: {last, data}
    logic [128:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;
    logic [127:0]  head_data;
    logic          head_last;

    logic [CW-1:0] idx_q, idx_d;
    logic [63:0]   aad_bits_q, pt_bits_q;
    logic [57:0]   total_full;
    logic [CW-1:0] total_c, aad_blk_c, cur_idx;
    logic          bad_len, oversize, emit, is_pt, is_final, latch;

    logic [127:0]  key_q, aad_q, plain_q, size_q;
    logic [95:0]   iv_q;
    logic          new_q, pti_q, busy_q, err_q;
    logic [1:0]    code_q;
    logic [127:0]  aad_d, plain_d;
    logic          new_d, pti_d, err_d;
    logic [1:0]    code_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign s_blk_ready = !rst && (count_q != CW'(DEPTH));
    assign s_hdr_ready = !rst && (state_q == IDLE);
    assign push        = s_blk_valid && s_blk_ready;
    assign {head_last, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_blk_last, s_blk_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Block counts from the latched header; the narrow forms are only used once the
    // frame has passed the size check, so they cannot overflow there.
    assign total_full = 58'(({1'b0, aad_bits_q} + {1'b0, pt_bits_q}) >> 7);
    assign total_c    = total_full[CW-1:0];
    assign aad_blk_c  = aad_bits_q[CW+6:7];
    assign bad_len    = (|aad_bits_q[6:0]) || (|pt_bits_q[6:0]) || (pt_bits_q == '0);
    assign oversize   = total_full > 58'(DEPTH);

    assign cur_idx  = (state_q == SEND) ? idx_q : '0;
    assign is_pt    = cur_idx >= aad_blk_c;
    assign is_final = cur_idx == (total_c - 1'b1);

    // Block 0 is popped in the FILL cycle that sees the full frame, keeping the
    // header-to-first-block latency at three cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        emit    = 1'b0;
        latch   = 1'b0;
        err_d   = 1'b0;
        code_d  = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (s_hdr_valid && s_hdr_ready) begin
                    latch   = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad_len) begin
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    state_d = DRAIN;
                end else if (oversize) begin
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                    state_d = DRAIN;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (count_q >= total_c) begin
                    pop     = 1'b1;
                    emit    = 1'b1;
                    idx_d   = CW'(1);
                    state_d = is_final ? IDLE : SEND;
                end
            end
            SEND: begin
                pop   = 1'b1;
                emit  = 1'b1;
                idx_d = idx_q + 1'b1;
                if (is_final) state_d = IDLE;
            end
            DRAIN: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        new_d   = emit && (cur_idx == '0);
        pti_d   = emit && is_pt;
        aad_d   = (emit && !is_pt) ? head_data : '0;
        plain_d = (emit && is_pt) ? head_data : '0;
        if (emit && (head_last != is_final)) begin
            err_d  = 1'b1;
            code_d = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            aad_bits_q <= '0;
            pt_bits_q  <= '0;
            key_q      <= '0;
            iv_q       <= '0;
            size_q     <= '0;
            aad_q      <= '0;
            plain_q    <= '0;
            new_q      <= 1'b0;
            pti_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch) begin
                aad_bits_q <= s_hdr_aad_bits;
                pt_bits_q  <= s_hdr_pt_bits;
                key_q      <= s_hdr_key;
                iv_q       <= s_hdr_iv;
                size_q     <= {s_hdr_aad_bits, s_hdr_pt_bits};
            end
            aad_q   <= aad_d;
            plain_q <= plain_d;
            new_q   <= new_d;
            pti_q   <= pti_d;
            busy_q  <= (state_d != IDLE);
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign o_cipher_key    = key_q;
    assign o_iv            = iv_q;
    assign o_instance_size = size_q;
    assign o_aad           = aad_q;
    assign o_plain_text    = plain_q;
    assign o_new_instance  = new_q;
    assign o_pt_instance   = pti_q;
    assign o_busy          = busy_q;
    assign o_err           = err_q;
    assign o_err_code      = code_q;
endmodule

// File: tb/tb_gcm_frame_feeder.sv
// tb_gcm_frame_feeder: directed and randomized frames checked against a frame-level
// model of the expected block stream, error pulses and latched header fields.
module tb_gcm_frame_feeder;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_hdr_valid = 1'b0, s_hdr_ready;
    logic [127:0] s_hdr_key = '0;
    logic [95:0]  s_hdr_iv = '0;
    logic [63:0]  s_hdr_aad_bits = '0, s_hdr_pt_bits = '0;
    logic         s_blk_valid = 1'b0, s_blk_ready;
    logic [127:0] s_blk_data = '0;
    logic         s_blk_last = 1'b0;
    logic [127:0] o_cipher_key, o_aad, o_plain_text, o_instance_size;
    logic [95:0]  o_iv;
    logic         o_new_instance, o_pt_instance, o_busy, o_err;
    logic [1:0]   o_err_code;

    gcm_frame_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_key(s_hdr_key),
        .s_hdr_iv(s_hdr_iv), .s_hdr_aad_bits(s_hdr_aad_bits), .s_hdr_pt_bits(s_hdr_pt_bits),
        .s_blk_valid(s_blk_valid), .s_blk_ready(s_blk_ready), .s_blk_data(s_blk_data),
        .s_blk_last(s_blk_last),
        .o_cipher_key(o_cipher_key), .o_aad(o_aad), .o_plain_text(o_plain_text), .o_iv(o_iv),
        .o_instance_size(o_instance_size), .o_new_instance(o_new_instance),
        .o_pt_instance(o_pt_instance), .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         nw;
        logic         pt;
        logic [127:0] aad;
        logic [127:0] pl;
        int           cyc;
    } rec_t;

    rec_t mon_q[$];
    int   cyc = 0;
    int   err_cnt [4] = '{0, 0, 0, 0};
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        rec_t r;
        if (!rst) begin
            if (o_new_instance || o_pt_instance || (o_aad != '0) || (o_plain_text != '0)) begin
                r.nw = o_new_instance; r.pt = o_pt_instance;
                r.aad = o_aad; r.pl = o_plain_text; r.cyc = cyc;
                mon_q.push_back(r);
            end
            if (o_err) err_cnt[o_err_code] = err_cnt[o_err_code] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int pick_gap(input int g);
        return (g >= 0) ? g : int'($urandom_range(0, 3));
    endfunction

    task automatic push_blk(input logic [127:0] d, input logic l, input int gap);
        bit ok = 0;
        repeat (gap + 1) @(posedge clk);
        #1;
        s_blk_data = d; s_blk_last = l; s_blk_valid = 1'b1;
        for (int t = 0; t < 4000 && !ok; t++) begin
            @(negedge clk);
            if (s_blk_ready) begin
                @(posedge clk);
                ok = 1;
            end
        end
        #1 s_blk_valid = 1'b0;
        check_val("blk_accept", ok, 1'b1);
    endtask

    task automatic send_hdr(input logic [127:0] key, input logic [95:0] iv,
                            input logic [63:0] a, input logic [63:0] p);
        bit ok = 0;
        @(posedge clk);
        #1;
        s_hdr_key = key; s_hdr_iv = iv; s_hdr_aad_bits = a; s_hdr_pt_bits = p;
        s_hdr_valid = 1'b1;
        for (int t = 0; t < 4000 && !ok; t++) begin
            @(negedge clk);
            if (s_hdr_ready) begin
                @(posedge clk);
                ok = 1;
            end
        end
        #1 s_hdr_valid = 1'b0;
        check_val("hdr_accept", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 4000 && !ok; t++) begin
            @(negedge clk);
            if (!o_busy) ok = 1;
        end
        check_val("idle_reached", ok, 1'b1);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_aad"}, o_aad, '0);
        check_val({tag, "_pt"}, o_plain_text, '0);
        check_val({tag, "_key"}, o_cipher_key, '0);
        check_val({tag, "_iv"}, o_iv, '0);
        check_val({tag, "_size"}, o_instance_size, '0);
        check_val({tag, "_flags"}, {o_new_instance, o_pt_instance, o_busy, o_err, o_err_code}, '0);
        check_val({tag, "_rdy"}, {s_hdr_ready, s_blk_ready}, 2'b00);
    endtask

    // Frame-level reference: decides from the header rules alone whether the frame
    // is rejected (and with which code) or what block sequence it must produce.
    task automatic run_frame(input logic [63:0] aadb, input logic [63:0] ptb, input int nblk,
                             input int lastpos, input bit preload, input int gap);
        logic [127:0] data [$];
        logic         lastf [$];
        logic [127:0] key;
        logic [95:0]  iv;
        int total, aadblk, lat, e1, e2, e3, b1, b2, b3;
        bit good;
        for (int i = 0; i < nblk; i++) begin
            data.push_back({$urandom, $urandom, $urandom, $urandom});
            lastf.push_back(i == lastpos);
        end
        key = {$urandom, $urandom, $urandom, $urandom};
        iv  = {$urandom, $urandom, $urandom};
        total  = int'((aadb + ptb) / 128);
        aadblk = int'(aadb / 128);
        good = 0; e1 = 0; e2 = 0; e3 = 0; lat = 0;
        if ((aadb % 128 != 0) || (ptb % 128 != 0) || (ptb == 0)) e1 = 1;
        else if (total > DEPTH) e3 = 1;
        else begin
            good = 1;
            for (int i = 0; i < total; i++)
                if (lastf[i] != (i == total - 1)) e2++;
        end
        b1 = err_cnt[1]; b2 = err_cnt[2]; b3 = err_cnt[3];
        mon_q.delete();
        if (preload)
            for (int i = 0; i < nblk; i++) push_blk(data[i], lastf[i], pick_gap(gap));
        fork
            begin
                send_hdr(key, iv, aadb, ptb);
                if (preload && good) begin
                    for (int k = 1; k <= 20 && lat == 0; k++) begin
                        @(negedge clk);
                        if (o_new_instance) lat = k;
                    end
                    check_val("latency", lat, 3);
                end
            end
            begin
                if (!preload)
                    for (int i = 0; i < nblk; i++) push_blk(data[i], lastf[i], pick_gap(gap));
            end
        join
        wait_idle();
        repeat (3) @(negedge clk);
        check_val("n_blocks", mon_q.size(), good ? total : 0);
        if (good) begin
            for (int i = 0; i < total && i < mon_q.size(); i++) begin
                check_val($sformatf("flags[%0d]", i), {mon_q[i].nw, mon_q[i].pt},
                          {(i == 0), (i >= aadblk)});
                check_val($sformatf("aad[%0d]", i), mon_q[i].aad, (i < aadblk) ? data[i] : '0);
                check_val($sformatf("pt[%0d]", i), mon_q[i].pl, (i >= aadblk) ? data[i] : '0);
                check_val($sformatf("cycle[%0d]", i), mon_q[i].cyc - mon_q[0].cyc, i);
            end
        end
        check_val("err01", err_cnt[1] - b1, e1);
        check_val("err10", err_cnt[2] - b2, e2);
        check_val("err11", err_cnt[3] - b3, e3);
        check_val("key", o_cipher_key, key);
        check_val("iv", o_iv, iv);
        check_val("inst_size", o_instance_size, {aadb, ptb});
    endtask

    task automatic reset_mid_send();
        bit ok = 0;
        for (int i = 0; i < 5; i++) push_blk({$urandom, $urandom, $urandom, $urandom}, i == 4, 0);
        send_hdr({4{$urandom}}, {3{$urandom}}, 64'd256, 64'd384);
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (o_new_instance) ok = 1;
        end
        check_val("rst_frame_started", ok, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("rst_ready_low", {s_hdr_ready, s_blk_ready}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check_quiet("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_release", {s_hdr_ready, s_blk_ready, o_busy}, 3'b110);
        run_frame(64'd128, 64'd256, 3, 2, 1'b1, -1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, p, nb, lp, mode, sel;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("ready_after_reset", {s_hdr_ready, s_blk_ready, o_busy}, 3'b110);

        run_frame(64'd256, 64'd384, 5, 4, 1'b1, 0);     // preloaded 2 AAD + 3 PT
        run_frame(64'd256, 64'd384, 5, 4, 1'b0, 3);     // header first, gapped blocks
        run_frame(64'd0, 64'd128, 1, 0, 1'b1, 0);       // single PT block
        run_frame(64'd0, 64'd100, 3, 2, 1'b0, 1);       // bad length, drained
        run_frame(64'd128, 64'd256, 3, 2, 1'b1, 1);     // recovers after drain
        run_frame(64'd0, 64'd8960, 4, 3, 1'b0, 0);      // 70 blocks: oversize
        run_frame(64'd256, 64'd384, 5, 2, 1'b1, 0);     // early last flag
        reset_mid_send();

        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 3));
            p  = int'($urandom_range(1, 4));
            nb = int'($urandom_range(1, 4));
            case (mode)
                0: begin
                    sel = int'($urandom_range(0, 2));
                    if (sel == 0)
                        run_frame(64'(a * 128), 64'(p * 128 + int'($urandom_range(1, 127))),
                                  nb, nb - 1, 1'($urandom), -1);
                    else if (sel == 1)
                        run_frame(64'(a * 128 + 64), 64'(p * 128), nb, nb - 1, 1'($urandom), -1);
                    else
                        run_frame(64'(a * 128), 64'd0, nb, nb - 1, 1'($urandom), -1);
                end
                1: run_frame(64'(a * 128), 64'(128 * int'($urandom_range(65, 80))),
                             nb, nb - 1, 1'($urandom), -1);
                2: begin
                    lp = int'($urandom_range(0, a + p)) - 1;
                    run_frame(64'(a * 128), 64'(p * 128), a + p, lp, 1'($urandom), -1);
                end
                default: run_frame(64'(a * 128), 64'(p * 128), a + p, a + p - 1, 1'($urandom), -1);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
